seq_detect_param: RTL and testbench
===================================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter MAX_LEN, default 8, maximum pattern length in bits; the legal range is 4..32.
REQ-002 Parameter CNT_W, default 8, width of the match counter.
REQ-003 Derived width LEN_W = $clog2(MAX_LEN)+1, width of the length fields.
REQ-004 clk  input  1  single clock, all state updates on the rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 a  input  1  serial data bit.
REQ-007 in_valid  input  1  a is sampled only in cycles where in_valid=1.
REQ-008 cfg_load  input  1  one-cycle request to load a new configuration.
REQ-009 cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is the first bit received and bit [0] is the last.
REQ-010 cfg_len  input  LEN_W  pattern length; the legal range is 1..MAX_LEN.
REQ-011 cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping detection.
REQ-012 cnt_clr  input  1  synchronous clear of match_cnt.
REQ-013 y  output  1  registered Moore match flag.
REQ-014 match_cnt  output  CNT_W  saturating count of matches.
REQ-015 cfg_err  output  1  one-cycle pulse when a cfg_load carries an illegal cfg_len.

Function
REQ-016 The block SHALL hold the active configuration in registers: pat[MAX_LEN-1:0], len, and ovl.
REQ-017 On each accepted bit (in_valid=1, cfg_load=0), the block SHALL update the history as hist <= {hist[MAX_LEN-2:0], a}.
REQ-018 On each accepted bit, the fill count SHALL increment, saturating at MAX_LEN.
REQ-019 A match SHALL be computed from the updated values: new_fill >= len and new_hist[len-1:0] == pat[len-1:0].
REQ-020 On a match, y SHALL go to 1 on the same clock edge that accepts the final bit, so y is visible in the following cycle.
REQ-021 On a match, match_cnt SHALL increment by 1, saturating at 2^CNT_W-1.
REQ-022 On an accepted bit that is not a match, y SHALL go to 0 on that clock edge.
REQ-023 In cycles with in_valid=0, y, hist, fill and match_cnt SHALL hold their values (Moore hold).
REQ-024 Overlapping mode (ovl=1): after a match, fill SHALL continue counting, so a pattern suffix can begin the next match.
REQ-025 Non-overlapping mode (ovl=0): a match SHALL set fill to 0, so the next match needs len fresh bits.
REQ-026 A legal cfg_load SHALL load pat, len and ovl.
REQ-027 A legal cfg_load SHALL clear hist, fill and y, and SHALL leave match_cnt unchanged.
REQ-028 An illegal cfg_load (cfg_len=0 or cfg_len>MAX_LEN) SHALL leave pat, len, ovl, hist, fill and y unchanged, and SHALL pulse cfg_err for 1 cycle.
REQ-029 cfg_load SHALL take priority over in_valid in the same cycle, and the data bit in that cycle SHALL be dropped.
REQ-030 When cnt_clr=1, match_cnt SHALL be 0 next cycle, even if a match occurs in the same cycle (clear wins).
REQ-031 cnt_clr SHALL NOT affect y.
REQ-032 Pattern bits above len-1 SHALL be ignored in the comparison.
REQ-033 The block SHALL have no combinational path from inputs to any output.

Reset
REQ-034 When rst=1, the block SHALL load pat = 1101 (zero-extended), len = 4 and ovl = 1.
REQ-035 When rst=1, the block SHALL clear hist, fill, y, match_cnt and cfg_err on the next edge.
REQ-036 rst SHALL take priority over cfg_load, cnt_clr and in_valid.
REQ-037 Reset asserted mid-sequence SHALL discard all partial history.

Verification
REQ-038 Defaults, in_valid=1, stream 1,1,0,1,1,0,1 -> y=1 in the cycles after bits 4 and 7, match_cnt=2.
REQ-039 Load len=4, pattern 1101, ovl=0, same stream -> y=1 only after bit 4, match_cnt=1; 1,1,0,1 appended -> second match after bit 11.
REQ-040 Defaults, stream 1,1,0,1 with in_valid=0 gaps of 3 cycles between bits -> single match after bit 4; y stays 1 through the gaps until the next accepted bit.
REQ-041 Load len=1, pattern 1, stream 1,1,0,1 -> match_cnt=3; y pattern 1,1,0,1.
REQ-042 cfg_load with cfg_len=0, then with cfg_len=MAX_LEN+1 -> cfg_err pulses each time; the default 1101 detection still works.
REQ-043 CNT_W=2, seven matches -> match_cnt saturates at 3; cnt_clr together with a match -> 0; rst after bits 1,1,0 then 1 -> no match.

Source files
------------

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - runtime-configurable serial pattern detector with saturating match counter
module seq_detect_param #(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               a,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               y,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_err
);

    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   len;
    logic               ovl;
    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;

    logic               len_legal;
    logic               accept;
    logic               hit;
    logic [MAX_LEN-1:0] new_hist;
    logic [LEN_W-1:0]   new_fill;
    logic [MAX_LEN-1:0] mask;

    always_comb begin
        len_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
        accept    = in_valid && !cfg_load;
        new_hist  = {hist[MAX_LEN-2:0], a};
        new_fill  = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
        // Only the low len bits take part in the comparison
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len);
        end
        hit = accept && (new_fill >= len) && (((new_hist ^ pat) & mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat       <= MAX_LEN'(4'b1101);
            len       <= LEN_W'(4);
            ovl       <= 1'b1;
            hist      <= '0;
            fill      <= '0;
            y         <= 1'b0;
            match_cnt <= '0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= cfg_load && !len_legal;
            if (cfg_load) begin
                if (len_legal) begin
                    pat  <= cfg_pattern;
                    len  <= cfg_len;
                    ovl  <= cfg_overlap;
                    hist <= '0;
                    fill <= '0;
                    y    <= 1'b0;
                end
            end else if (in_valid) begin
                hist <= new_hist;
                // Non-overlapping mode restarts the fill so the next match needs len fresh bits
                fill <= (hit && !ovl) ? '0 : new_fill;
                y    <= hit;
            end
            if (cnt_clr) begin
                match_cnt <= '0;
            end else if (hit && (match_cnt != '1)) begin
                match_cnt <= match_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - scoreboard bench for seq_detect_param against a queue-based reference model
module tb_seq_detect_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b1, a = 1'b0, in_valid = 1'b0, cfg_load = 1'b0;
    logic             cfg_overlap = 1'b0, cnt_clr = 1'b0;
    logic [7:0]       cfg_pattern = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             y_a, y_b, err_a, err_b;
    logic [7:0]       cnt_a;
    logic [1:0]       cnt_b;

    seq_detect_param #(.MAX_LEN(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .a(a), .in_valid(in_valid), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .y(y_a), .match_cnt(cnt_a), .cfg_err(err_a)
    );

    seq_detect_param #(.MAX_LEN(8), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .a(a), .in_valid(in_valid), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .y(y_b), .match_cnt(cnt_b), .cfg_err(err_b)
    );

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int cyc;
        bit y;
        int ca;
        int cb;
        bit err;
    } exp_t;
    exp_t sb[$];

    // Reference model: raw accepted-bit queue plus a count of bits since the last restart
    bit [7:0] pat_m;
    int       len_m, fresh, cnt_am, cnt_bm;
    bit       ovl_m, y_m, err_m;
    bit       hist_q[$];

    task automatic cmp(input string nm, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc_cnt, act, exp);
        end
    endtask

    task automatic model(input bit r, v, ab, cl, input bit [7:0] p, input int ln,
                         input bit o, cc);
        bit m;
        int sz;
        m = 1'b0;
        if (r) begin
            pat_m = 8'b1101; len_m = 4; ovl_m = 1'b1;
            hist_q.delete(); fresh = 0; y_m = 1'b0;
            cnt_am = 0; cnt_bm = 0; err_m = 1'b0;
            return;
        end
        err_m = cl && (ln == 0 || ln > MAX_LEN);
        if (cl) begin
            if (!err_m) begin
                pat_m = p; len_m = ln; ovl_m = o;
                hist_q.delete(); fresh = 0; y_m = 1'b0;
            end
        end else if (v) begin
            hist_q.push_back(ab);
            if (hist_q.size() > MAX_LEN) void'(hist_q.pop_front());
            fresh++;
            sz = hist_q.size();
            m = (fresh >= len_m);
            for (int i = 0; i < len_m; i++)
                if (m && hist_q[sz-1-i] != pat_m[i]) m = 1'b0;
            y_m = m;
            if (m && !ovl_m) fresh = 0;
        end
        if (cc) begin
            cnt_am = 0; cnt_bm = 0;
        end else if (m) begin
            if (cnt_am < 255) cnt_am++;
            if (cnt_bm < 3) cnt_bm++;
        end
    endtask

    task automatic drive(input bit r, v, ab, cl, input bit [7:0] p, input int ln,
                         input bit o, cc);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; in_valid = v; a = ab; cfg_load = cl;
        cfg_pattern = p; cfg_len = LEN_W'(ln); cfg_overlap = o; cnt_clr = cc;
        model(r, v, ab, cl, p, ln, o, cc);
        e.cyc = cyc_cnt + 1; e.y = y_m; e.ca = cnt_am; e.cb = cnt_bm; e.err = err_m;
        sb.push_back(e);
    endtask

    task automatic bit_in(input bit b, input bit cc = 1'b0);
        drive(1'b0, 1'b1, b, 1'b0, 8'h00, 0, 1'b0, cc);
    endtask
    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    endtask
    task automatic do_rst();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    endtask
    task automatic load(input bit [7:0] p, input int ln, input bit o);
        drive(1'b0, 1'b0, 1'b0, 1'b1, p, ln, o, 1'b0);
    endtask
    task automatic stream(input bit [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) bit_in(bits[i]);
    endtask
    task automatic settle();
        idle();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            e = sb.pop_front();
            if (e.cyc == cyc_cnt) begin
                cmp("y_a", 32'(y_a), int'(e.y));
                cmp("y_b", 32'(y_b), int'(e.y));
                cmp("cnt_a", 32'(cnt_a), e.ca);
                cmp("cnt_b", 32'(cnt_b), e.cb);
                cmp("err_a", 32'(err_a), int'(e.err));
                cmp("err_b", 32'(err_b), int'(e.err));
            end
        end
    end

    initial begin
        do_rst();
        settle();
        cmp("rst_y", 32'(y_a), 0);
        cmp("rst_cnt", 32'(cnt_a), 0);

        stream(32'b1101101, 7);
        settle();
        cmp("dflt_cnt", 32'(cnt_a), 2);
        cmp("dflt_y", 32'(y_a), 1);

        load(8'b1101, 4, 1'b0);
        stream(32'b1101101, 7);
        settle();
        cmp("novl_cnt", 32'(cnt_a), 3);
        cmp("novl_y", 32'(y_a), 0);
        stream(32'b1101, 4);
        settle();
        cmp("novl_cnt2", 32'(cnt_a), 4);

        do_rst();
        for (int i = 3; i >= 0; i--) begin
            bit_in(1'(4'b1101 >> i));
            repeat (3) idle();
        end
        @(negedge clk);
        cmp("gap_y", 32'(y_a), 1);
        cmp("gap_cnt", 32'(cnt_a), 1);

        load(8'b1, 1, 1'b1);
        stream(32'b1101, 4);
        settle();
        cmp("len1_cnt", 32'(cnt_a), 4);

        do_rst();
        load(8'hff, 0, 1'b0);
        settle();
        cmp("err_len0", 32'(err_a), 1);
        load(8'hff, MAX_LEN + 1, 1'b0);
        settle();
        cmp("err_len9", 32'(err_a), 1);
        stream(32'b1101, 4);
        settle();
        cmp("err_keep_cnt", 32'(cnt_a), 1);

        do_rst();
        stream(32'b1101, 4);
        for (int k = 0; k < 6; k++) stream(32'b101, 3);
        settle();
        cmp("sat_b", 32'(cnt_b), 3);
        cmp("sat_a", 32'(cnt_a), 7);
        bit_in(1'b1);
        bit_in(1'b0);
        bit_in(1'b1, 1'b1);
        settle();
        cmp("clr_wins", 32'(cnt_a), 0);
        cmp("clr_keeps_y", 32'(y_a), 1);

        do_rst();
        stream(32'b110, 3);
        do_rst();
        bit_in(1'b1);
        settle();
        cmp("rst_mid_y", 32'(y_a), 0);

        for (int n = 0; n < 1500; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 1)
                do_rst();
            else if (r < 5)
                drive(1'b0, 1'($urandom), 1'($urandom), 1'b1, 8'($urandom),
                      int'($urandom_range(0, 10)), 1'($urandom), 1'($urandom_range(0, 9) == 0));
            else
                drive(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'b0, 8'h00, 0, 1'b0,
                      1'($urandom_range(0, 39) == 0));
        end
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp("sb_drain", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
